// File: rtl/tick_timer_bank.sv
// Prescaled tick generator feeding a bank of independent countdown timers.
// Each channel counts whole ticks after a load and pulses expire when the count runs out.
//
// state | meaning
// IDLE  | channel stopped, remain held at 0, ticks ignored
// RUN   | counting ticks down from the latched period
module tick_timer_bank #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1,
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic                    tick,
   input  logic [NUM_CH-1:0]       ch_load,
   input  logic [NUM_CH-1:0]       ch_mode,
   input  logic [NUM_CH*CNT_W-1:0] ch_period,
   input  logic [NUM_CH-1:0]       ch_stop,
   output logic [NUM_CH-1:0]       ch_busy,
   output logic [NUM_CH-1:0]       ch_expire,
   output logic [NUM_CH*CNT_W-1:0] ch_remain
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   generate
      if (DIV < 2) begin : g_div_chk
         $error("tick_timer_bank: CLK_HZ/TICK_HZ must be at least 2");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   logic [PW-1:0] pre_q, pre_d;
   logic          tick_q, tick_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   // en low freezes the count so a resumed run finishes the interrupted interval
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (en) begin
         tick_d = (pre_q == LAST);
         pre_d  = (pre_q == LAST) ? '0 : pre_q + PW'(1);
      end
   end

   assign tick = tick_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_e      state_q, state_d;
      logic [CNT_W-1:0] remain_q, remain_d;
      logic [CNT_W-1:0] period_q, period_d;
      logic           mode_q, mode_d;
      logic           expire_q, expire_d;
      logic [CNT_W-1:0] period_in;

      assign period_in = ch_period[i*CNT_W +: CNT_W];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
         end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
         end
      end

      // load beats stop beats tick; a tick coinciding with load is not counted
      always_comb begin
         state_d  = state_q;
         remain_d = remain_q;
         period_d = period_q;
         mode_d   = mode_q;
         expire_d = 1'b0;
         if (ch_load[i]) begin
            period_d = period_in;
            mode_d   = ch_mode[i];
            if (period_in == '0) begin
               state_d  = ST_IDLE;
               remain_d = '0;
               expire_d = 1'b1;
            end else begin
               state_d  = ST_RUN;
               remain_d = period_in;
            end
         end else if (ch_stop[i]) begin
            state_d  = ST_IDLE;
            remain_d = '0;
         end else if (state_q == ST_RUN && tick_q) begin
            if (remain_q > CNT_W'(1)) begin
               remain_d = remain_q - CNT_W'(1);
            end else begin
               expire_d = 1'b1;
               if (mode_q) begin
                  remain_d = period_q;
               end else begin
                  remain_d = '0;
                  state_d  = ST_IDLE;
               end
            end
         end
      end

      assign ch_busy[i]                  = (state_q == ST_RUN);
      assign ch_expire[i]                = expire_q;
      assign ch_remain[i*CNT_W +: CNT_W] = remain_q;
   end

endmodule
